rr_grant_arbiter8: RTL and testbench

- Round-robin arbiter that shares one resource among 8 requesters.
- The winner's 3-bit index drives a 3-to-8 one-hot decoder with active-high enable. That decoder produces the grant vector, so at most one grant line can be high at any time.
- Each grant is held until the requester drops its request, or until an optional hold limit expires. Either way, at least one idle cycle follows before the next grant.
- It sits between the requester array and the shared resource's select logic.

---
 rtl/rr_grant_arbiter8_pkg.sv | 12 +
 rtl/grant_dec3.sv | 15 +
 rtl/rr_grant_arbiter8.sv | 100 ++++++++++
 tb/tb_rr_grant_arbiter8.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_arbiter8_pkg.sv
// rtl/rr_grant_arbiter8_pkg.sv - shared constants and state type for the 8-way round-robin arbiter
package rr_grant_arbiter8_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/grant_dec3.sv
// rtl/grant_dec3.sv - 3-to-8 one-hot decoder with active-high enable
module grant_dec3
  import rr_grant_arbiter8_pkg::*;
(
  input  logic               en,
  input  logic [IDX_W-1:0]   sel,
  output logic [NUM_REQ-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_arbiter8.sv
// rtl/rr_grant_arbiter8.sv - round-robin arbiter sharing one resource among 8 requesters
module rr_grant_arbiter8
  import rr_grant_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               timeout
);

  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;

  logic              found;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  pos;

  // Scan upward from ptr; the 3-bit add wraps the search naturally.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    pos   = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = ptr_q + IDX_W'(i);
      if (!found && req[pos]) begin
        found = 1'b1;
        win   = pos;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_GRANT;
          idx_d   = win;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        if (!req[idx_q]) begin
          state_d = ST_IDLE;
          ptr_d   = idx_q + IDX_W'(1);
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST)) begin
          // Release has priority over the limit, so timeout only fires here.
          state_d   = ST_IDLE;
          ptr_d     = idx_q + IDX_W'(1);
          timeout_d = 1'b1;
        end else if (MAX_HOLD != 0) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_valid = (state_q == ST_GRANT);
  assign gnt_idx   = idx_q;
  assign timeout   = timeout_q;

  grant_dec3 u_dec (
    .en  (gnt_valid),
    .sel (idx_q),
    .y   (gnt)
  );

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// tb/tb_rr_grant_arbiter8.sv - self-checking bench for rr_grant_arbiter8
module tb_rr_grant_arbiter8;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst16, rst4;
  logic [7:0] req16, req4;
  logic [7:0] gnt16, gnt4;
  logic       val16, val4;
  logic [2:0] idx16, idx4;
  logic       to16, to4;

  rr_grant_arbiter8 #(.MAX_HOLD(16)) dut16 (
    .clk(clk), .rst(rst16), .req(req16),
    .gnt(gnt16), .gnt_valid(val16), .gnt_idx(idx16), .timeout(to16)
  );

  rr_grant_arbiter8 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst4), .req(req4),
    .gnt(gnt4), .gnt_valid(val4), .gnt_idx(idx4), .timeout(to4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: who owns the resource, for how many cycles so far, and where the next search starts.
  int m_busy[2];
  int m_idx[2];
  int m_ptr[2];
  int m_cnt[2];
  int m_to[2];
  int m_k[2] = '{16, 4};

  function automatic void model_step(int u, logic r, logic [7:0] rq);
    if (r) begin
      m_busy[u] = 0; m_idx[u] = 0; m_ptr[u] = 0; m_cnt[u] = 0; m_to[u] = 0;
      return;
    end
    m_to[u] = 0;
    if (m_busy[u] == 0) begin
      for (int d = 0; d < 8; d++) begin
        int p;
        p = (m_ptr[u] + d) % 8;
        if (rq[p]) begin
          m_busy[u] = 1; m_idx[u] = p; m_cnt[u] = 1;
          break;
        end
      end
    end else if (!rq[m_idx[u]]) begin
      m_busy[u] = 0; m_ptr[u] = (m_idx[u] + 1) % 8;
    end else if (m_k[u] != 0 && m_cnt[u] == m_k[u]) begin
      m_busy[u] = 0; m_ptr[u] = (m_idx[u] + 1) % 8; m_to[u] = 1;
    end else begin
      m_cnt[u] = m_cnt[u] + 1;
    end
  endfunction

  function automatic logic [31:0] exp_pack(int u);
    logic [7:0] g;
    g = (m_busy[u] != 0) ? 8'(1 << m_idx[u]) : 8'h00;
    return {19'b0, m_to[u] != 0, m_busy[u] != 0, 3'(m_idx[u]), g};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    model_step(0, rst16, req16);
    model_step(1, rst4, req4);
    @(posedge clk);
    #1;
    check("model16", {19'b0, to16, val16, idx16, gnt16}, exp_pack(0));
    check("model4",  {19'b0, to4,  val4,  idx4,  gnt4},  exp_pack(1));
    check("onehot16", 32'($onehot0(gnt16)), 32'd1);
    check("onehot4",  32'($onehot0(gnt4)),  32'd1);
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       val;
    logic [2:0] idx;
    logic       to;
  } vec_t;

  vec_t       vt[18];
  logic [7:0] exp_g;
  logic [7:0] to_seq_g[11];
  logic       to_seq_t[11];
  int         timer[8];
  int         seen;
  logic [7:0] prev_g;

  initial begin
    rst16 = 1'b1; rst4 = 1'b1; req16 = 8'h00; req4 = 8'h00;
    for (int u = 0; u < 2; u++) begin
      m_busy[u] = 0; m_idx[u] = 0; m_ptr[u] = 0; m_cnt[u] = 0; m_to[u] = 0;
    end

    // Reset, single requester and wrap-around on MAX_HOLD=16.
    vt[0]  = '{1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0};
    vt[1]  = '{1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0};
    vt[2]  = '{1'b0, 8'hFF, 8'h01, 1'b1, 3'd0, 1'b0};
    vt[3]  = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
    vt[4]  = '{1'b0, 8'h08, 8'h08, 1'b1, 3'd3, 1'b0};
    vt[5]  = '{1'b0, 8'h08, 8'h08, 1'b1, 3'd3, 1'b0};
    vt[6]  = '{1'b0, 8'h08, 8'h08, 1'b1, 3'd3, 1'b0};
    vt[7]  = '{1'b0, 8'h08, 8'h08, 1'b1, 3'd3, 1'b0};
    vt[8]  = '{1'b0, 8'h08, 8'h08, 1'b1, 3'd3, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd3, 1'b0};
    vt[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd3, 1'b0};
    vt[11] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd3, 1'b0};
    vt[12] = '{1'b0, 8'h80, 8'h80, 1'b1, 3'd7, 1'b0};
    vt[13] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd7, 1'b0};
    vt[14] = '{1'b0, 8'h81, 8'h01, 1'b1, 3'd0, 1'b0};
    vt[15] = '{1'b0, 8'h80, 8'h00, 1'b0, 3'd0, 1'b0};
    vt[16] = '{1'b0, 8'h80, 8'h80, 1'b1, 3'd7, 1'b0};
    vt[17] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd7, 1'b0};

    for (int i = 0; i < 18; i++) begin
      rst16 = vt[i].rst;
      req16 = vt[i].req;
      step();
      check($sformatf("vec%0d", i), {19'b0, to16, val16, idx16, gnt16},
            {19'b0, vt[i].to, vt[i].val, vt[i].idx, vt[i].gnt});
    end

    // Timeout on MAX_HOLD=4 with two requesters held continuously.
    to_seq_g = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h02};
    to_seq_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rst4 = 1'b1; req4 = 8'h06;
    step();
    rst4 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
      check($sformatf("tmo_gnt%0d", i), 32'(gnt4), 32'(to_seq_g[i]));
      check($sformatf("tmo_pulse%0d", i), 32'(to4), 32'(to_seq_t[i]));
    end
    req4 = 8'h00;

    // Rotation: each grantee drops one cycle after its grant and returns later.
    rst16 = 1'b1; req16 = 8'h00;
    step();
    rst16 = 1'b0; req16 = 8'hFF;
    for (int i = 0; i < 8; i++) timer[i] = 0;
    seen = 0;
    prev_g = 8'h00;
    for (int c = 0; c < 60 && seen < 9; c++) begin
      step();
      for (int i = 0; i < 8; i++) begin
        if (timer[i] > 0) begin
          timer[i]--;
          if (timer[i] == 0) req16[i] = 1'b1;
        end
      end
      if (gnt16 != 8'h00) begin
        exp_g = 8'(1 << (seen % 8));
        check($sformatf("rot%0d", seen), 32'(gnt16), 32'(exp_g));
        if (seen > 0) check($sformatf("rot_gap%0d", seen), 32'(prev_g), 32'h0);
        seen++;
        req16[idx16] = 1'b0;
        timer[idx16] = 3;
      end
      prev_g = gnt16;
    end
    check("rot_count", 32'(seen), 32'd9);

    // Reset in the middle of a grant.
    rst16 = 1'b1; req16 = 8'h00;
    step();
    rst16 = 1'b0; req16 = 8'h30;
    step();
    check("mid_gnt_a", 32'(gnt16), 32'h10);
    step();
    rst16 = 1'b1;
    step();
    check("mid_rst", {19'b0, to16, val16, idx16, gnt16}, 32'h0);
    rst16 = 1'b0;
    step();
    check("mid_regrant", {24'b0, val16, idx16, gnt16[3:0]}, {24'b0, 1'b1, 3'd4, 4'h0});
    check("mid_regrant_gnt", 32'(gnt16), 32'h10);

    // Randomized traffic on both instances against the reference.
    req16 = 8'h00; req4 = 8'h00;
    for (int c = 0; c < 1500; c++) begin
      rst16 = ($urandom_range(0, 99) == 0);
      rst4  = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 5) == 0) req16[i] = ~req16[i];
        if ($urandom_range(0, 7) == 0) req4[i]  = ~req4[i];
      end
      if ($urandom_range(0, 49) == 0) req4 = 8'hFF;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
